pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
Generic, parametrised pipeline-stage register for the in-order core. It is the next generation of the fixed-field decode/execute boundary register.
- Carries an opaque DATA_W-bit payload with a full valid/ready handshake on both sides.
- Optional 2-entry skid buffer: full throughput with a registered upstream ready.
- Synchronous flush for branch/trap redirect.
- Instantiated at the IF/ID, ID/EX and EX/LS boundaries; each stage packs its own fields into the payload.

Parameters:
DATA_W, 128, payload width in bits (>=1)
SKID_EN, 1, 1 = 2-entry skid buffer with registered o_pre_ready; 0 = single entry, combinational ready
RST_DATA, 0, reset value of the payload registers (DATA_W bits)

Ports:
clock  input  1  system clock
reset  input  1  reset
i_pre_valid  input  1  upstream payload valid
o_pre_ready  output  1  stage can accept this cycle
i_data  input  DATA_W  upstream payload
o_post_valid  output  1  payload valid to downstream
i_post_ready  input  1  downstream accepts
o_data  output  DATA_W  payload to downstream (head entry)
i_flush  input  1  kill all held and incoming entries
o_occupancy  output  2  entries held (0..2)

Interface decision: one clock `clock`; `reset` is asynchronous and active-high.

Behaviour:
- Definitions: in = i_pre_valid & o_pre_ready; out = o_post_valid & i_post_ready.
- Reset (async, active-high):
  - state EMPTY; o_post_valid = 0; o_occupancy = 0.
  - main and skid payload registers = RST_DATA, so o_data = RST_DATA.
  - o_pre_ready = 1 while reset is asserted and after release.
  - Reset mid-transfer drops all entries.
- Latency: a payload accepted at edge N is on o_data with o_post_valid = 1 after edge N. Order is strictly FIFO.
- o_data is always driven from the main register; it is stable while o_post_valid = 1 and i_post_ready = 0.
- SKID_EN = 1 state machine (o_pre_ready is a registered copy of state != FULL):
  - EMPTY: in -> BUSY, main <= i_data.
  - BUSY:
    - in & out -> BUSY, main <= i_data.
    - in & !out -> FULL, skid <= i_data.
    - !in & out -> EMPTY.
    - otherwise hold.
  - FULL (o_pre_ready = 0):
    - out -> BUSY, main <= skid.
    - otherwise hold.
  - o_post_valid = (state != EMPTY); o_occupancy = 0/1/2 for EMPTY/BUSY/FULL.
- SKID_EN = 0:
  - Single entry; FULL is unreachable.
  - o_pre_ready = !o_post_valid | i_post_ready (combinational).
  - Accepting while emptying replaces main the same cycle (back-to-back, no bubble).
- Flush (synchronous, highest priority over all other events):
  - Next state EMPTY; o_post_valid = 0 next cycle; the incoming payload in the same cycle is dropped.
  - Payload registers keep their value; their contents are don't-care while invalid.
  - o_pre_ready = 1 next cycle.
  - Flush is allowed together with out; downstream sees that transfer as completed.
- Data registers load only on the transitions listed above; no X propagation from i_data when i_pre_valid = 0.
- Verification assertion: o_pre_ready never depends combinationally on i_post_ready when SKID_EN = 1.

Decomposition:
- Shared package: state encodings (ST_EMPTY = 2'd0, ST_BUSY = 2'd1, ST_FULL = 2'd2) and occupancy width.
- Stage payload struct widths/offsets for IF/ID, ID/EX and EX/LS also live there, so packers/unpackers agree.
- No sub-module; the skid register is inline.

Test Plan:
- Reset, then stream 0x11, 0x22, 0x33 with i_pre_valid = 1 and i_post_ready = 1 -> outputs 0x11/0x22/0x33 on consecutive cycles starting 1 cycle after the first accept; o_occupancy = 1 throughout; no bubbles.
- SKID_EN = 1: accept 0xA then 0xB with i_post_ready = 0 -> o_occupancy = 2 and o_pre_ready = 0 on the next cycle; o_data = 0xA held. Raise ready -> 0xA then 0xB drained in order, o_pre_ready returns to 1.
- Assert i_flush while FULL (0xA, 0xB held) with i_pre_valid = 1 carrying 0xC -> next cycle o_post_valid = 0, o_occupancy = 0; 0xC never appears at the output.
- SKID_EN = 0: hold valid with i_post_ready toggling 1,0,1,0 -> o_pre_ready follows !o_post_valid | i_post_ready combinationally; exactly 2 payloads are delivered over the 4 cycles.
- Assert reset asynchronously mid-cycle while BUSY -> o_post_valid = 0 and o_data = RST_DATA immediately without a clock edge; o_pre_ready = 1 after release.
- Random valid/ready/flush for 10k cycles against a reference queue -> no loss, duplication or reordering of unflushed payloads; o_data stable while stalled.

Source files
------------

// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared definitions for the pipeline-stage register: FSM encodings, occupancy width
// and the payload layouts each boundary packs into the opaque data word.
package pipe_stage_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int OCC_W = 2;

  // IF/ID boundary payload
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
  } if_id_t;

  localparam int IF_ID_W         = $bits(if_id_t);
  localparam int IF_ID_PRED_LSB  = 0;
  localparam int IF_ID_INSTR_LSB = 1;
  localparam int IF_ID_PC_LSB    = 33;

  // ID/EX boundary payload
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_t;

  localparam int ID_EX_W          = $bits(id_ex_t);
  localparam int ID_EX_REG_WR_LSB = 0;
  localparam int ID_EX_MEM_WR_LSB = 1;
  localparam int ID_EX_MEM_RD_LSB = 2;
  localparam int ID_EX_ALU_OP_LSB = 3;
  localparam int ID_EX_RD_LSB     = 7;
  localparam int ID_EX_IMM_LSB    = 12;
  localparam int ID_EX_RS2_LSB    = 44;
  localparam int ID_EX_RS1_LSB    = 76;
  localparam int ID_EX_PC_LSB     = 108;

  // EX/LS boundary payload
  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_ls_t;

  localparam int EX_LS_W             = $bits(ex_ls_t);
  localparam int EX_LS_REG_WR_LSB    = 0;
  localparam int EX_LS_MEM_WR_LSB    = 1;
  localparam int EX_LS_MEM_RD_LSB    = 2;
  localparam int EX_LS_SIZE_LSB      = 3;
  localparam int EX_LS_RD_LSB        = 5;
  localparam int EX_LS_STORE_VAL_LSB = 10;
  localparam int EX_LS_ALU_RES_LSB   = 42;

  function automatic logic [IF_ID_W-1:0] pack_if_id(input if_id_t s);
    return s;
  endfunction

  function automatic if_id_t unpack_if_id(input logic [IF_ID_W-1:0] v);
    return if_id_t'(v);
  endfunction

  function automatic logic [ID_EX_W-1:0] pack_id_ex(input id_ex_t s);
    return s;
  endfunction

  function automatic id_ex_t unpack_id_ex(input logic [ID_EX_W-1:0] v);
    return id_ex_t'(v);
  endfunction

  function automatic logic [EX_LS_W-1:0] pack_ex_ls(input ex_ls_t s);
    return s;
  endfunction

  function automatic ex_ls_t unpack_ex_ls(input logic [EX_LS_W-1:0] v);
    return ex_ls_t'(v);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline register, 1-cycle latency, FIFO order; optional 2-entry skid gives a
// registered upstream ready at full throughput, otherwise ready = !valid | downstream ready.
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int              DATA_W   = 128,
  parameter bit              SKID_EN  = 1'b1,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_pre_valid,
  output logic              o_pre_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_post_valid,
  input  logic              i_post_ready,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_flush,
  output logic [OCC_W-1:0]  o_occupancy
);

  state_t            state;
  logic              valid_q;
  logic              ready_q;
  logic [OCC_W-1:0]  occ_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  // Skid mode never looks at i_post_ready combinationally on the upstream side.
  assign o_pre_ready  = SKID_EN ? ready_q : (!valid_q || i_post_ready);
  assign o_post_valid = valid_q;
  assign o_data       = main_q;
  assign o_occupancy  = occ_q;

  assign in_fire  = i_pre_valid && o_pre_ready;
  assign out_fire = valid_q && i_post_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      occ_q   <= 2'd0;
      main_q  <= RST_DATA;
      skid_q  <= RST_DATA;
    end else if (i_flush) begin
      // Payload registers keep their stale contents; they are invalid until refilled.
      state   <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      occ_q   <= 2'd0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state   <= ST_BUSY;
            valid_q <= 1'b1;
            occ_q   <= 2'd1;
            main_q  <= i_data;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= i_data;
          end else if (in_fire && SKID_EN) begin
            state   <= ST_FULL;
            occ_q   <= 2'd2;
            ready_q <= 1'b0;
            skid_q  <= i_data;
          end else if (out_fire) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
            occ_q   <= 2'd0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state   <= ST_BUSY;
            occ_q   <= 2'd1;
            ready_q <= 1'b1;
            main_q  <= skid_q;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          occ_q   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed and randomised checks of pipe_stage_skid_reg in skid and single-entry builds.
module tb_pipe_stage_skid_reg;

  localparam int              DW   = 8;
  localparam logic [DW-1:0]   RSTD = 8'hA5;

  logic clock = 1'b0;
  logic reset;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [1:0]    s_occ;

  logic          n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_flush;
  logic [DW-1:0] n_in_data, n_out_data;
  logic [1:0]    n_occ;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  pipe_stage_skid_reg #(.DATA_W(DW), .SKID_EN(1'b1), .RST_DATA(RSTD)) u_skid (
    .clock(clock), .reset(reset),
    .i_pre_valid(s_in_valid), .o_pre_ready(s_in_ready), .i_data(s_in_data),
    .o_post_valid(s_out_valid), .i_post_ready(s_out_ready), .o_data(s_out_data),
    .i_flush(s_flush), .o_occupancy(s_occ)
  );

  pipe_stage_skid_reg #(.DATA_W(DW), .SKID_EN(1'b0), .RST_DATA(RSTD)) u_single (
    .clock(clock), .reset(reset),
    .i_pre_valid(n_in_valid), .o_pre_ready(n_in_ready), .i_data(n_in_data),
    .o_post_valid(n_out_valid), .i_post_ready(n_out_ready), .o_data(n_out_data),
    .i_flush(n_flush), .o_occupancy(n_occ)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] sq[$];
    logic [DW-1:0] nq[$];
    logic [DW-1:0] delivered[$];
    logic [DW-1:0] nxt;
    logic [3:0]    pat;
    logic          ev, erdy, s_in, s_out, n_in, n_out;
    logic [1:0]    eocc;
    logic [DW-1:0] edata;

    reset = 1'b1;
    s_in_valid = 0; s_out_ready = 0; s_flush = 0; s_in_data = '0;
    n_in_valid = 0; n_out_ready = 0; n_flush = 0; n_in_data = '0;

    // Reset state
    #2;
    check("rst_s_valid", s_out_valid, 0);
    check("rst_s_occ",   s_occ,       0);
    check("rst_s_data",  s_out_data,  RSTD);
    check("rst_s_ready", s_in_ready,  1);
    check("rst_n_ready", n_in_ready,  1);
    check("rst_n_data",  n_out_data,  RSTD);
    @(negedge clock) reset = 1'b0;
    tick();
    check("rel_s_ready", s_in_ready, 1);
    check("rel_s_valid", s_out_valid, 0);

    // Streaming 0x11, 0x22, 0x33 on both builds
    s_in_valid = 1; s_out_ready = 1; s_in_data = 8'h11;
    n_in_valid = 1; n_out_ready = 1; n_in_data = 8'h11;
    tick();
    check("st1_s", {s_out_valid, s_occ, s_in_ready, s_out_data}, {1'b1, 2'd1, 1'b1, 8'h11});
    check("st1_n", {n_out_valid, n_occ, n_in_ready, n_out_data}, {1'b1, 2'd1, 1'b1, 8'h11});
    s_in_data = 8'h22; n_in_data = 8'h22;
    tick();
    check("st2_s", {s_out_valid, s_occ, s_in_ready, s_out_data}, {1'b1, 2'd1, 1'b1, 8'h22});
    check("st2_n", {n_out_valid, n_occ, n_in_ready, n_out_data}, {1'b1, 2'd1, 1'b1, 8'h22});
    s_in_data = 8'h33; n_in_data = 8'h33;
    tick();
    check("st3_s", {s_out_valid, s_occ, s_in_ready, s_out_data}, {1'b1, 2'd1, 1'b1, 8'h33});
    check("st3_n", {n_out_valid, n_occ, n_in_ready, n_out_data}, {1'b1, 2'd1, 1'b1, 8'h33});
    s_in_valid = 0; n_in_valid = 0;
    tick();
    check("st_drain_s", {s_out_valid, s_occ}, {1'b0, 2'd0});
    check("st_drain_n", {n_out_valid, n_occ}, {1'b0, 2'd0});

    // Skid fill with downstream stalled, then drain in order
    s_out_ready = 0; s_in_valid = 1; s_in_data = 8'h0A;
    tick();
    check("sk_busy", {s_out_valid, s_occ, s_in_ready, s_out_data}, {1'b1, 2'd1, 1'b1, 8'h0A});
    s_in_data = 8'h0B;
    tick();
    check("sk_full", {s_out_valid, s_occ, s_in_ready, s_out_data}, {1'b1, 2'd2, 1'b0, 8'h0A});
    s_in_valid = 0;
    s_out_ready = 1;
    #1;
    check("sk_ready_indep", s_in_ready, 0);
    tick();
    check("sk_drain1", {s_out_valid, s_occ, s_in_ready, s_out_data}, {1'b1, 2'd1, 1'b1, 8'h0B});
    tick();
    check("sk_drain2", {s_out_valid, s_occ, s_in_ready}, {1'b0, 2'd0, 1'b1});

    // Flush while full with 0x0C offered
    s_out_ready = 0; s_in_valid = 1; s_in_data = 8'h0A;
    tick();
    s_in_data = 8'h0B;
    tick();
    check("fl_full", s_occ, 2);
    s_in_data = 8'h0C; s_flush = 1;
    tick();
    check("fl_empty", {s_out_valid, s_occ, s_in_ready}, {1'b0, 2'd0, 1'b1});
    s_flush = 0; s_in_valid = 0; s_out_ready = 1;
    tick();
    check("fl_no_0c", {s_out_valid, s_occ}, {1'b0, 2'd0});

    // Flush from busy with an acceptable incoming payload and a completing output
    s_out_ready = 0; s_in_valid = 1; s_in_data = 8'h0D;
    tick();
    s_in_data = 8'h0E; s_flush = 1; s_out_ready = 1;
    tick();
    check("fl_busy", {s_out_valid, s_occ, s_in_ready}, {1'b0, 2'd0, 1'b1});
    s_flush = 0; s_in_valid = 0;
    tick();
    check("fl_no_0e", {s_out_valid, s_occ}, {1'b0, 2'd0});

    // Single-entry build: ready follows downstream ready while full
    n_in_valid = 1; n_out_ready = 0; n_in_data = 8'h40;
    tick();
    nxt = 8'h41;
    pat = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      n_out_ready = pat[k];
      n_in_data   = nxt;
      #1;
      check($sformatf("sg_ready%0d", k), n_in_ready, {31'd0, pat[k]});
      if (n_out_valid && n_out_ready) delivered.push_back(n_out_data);
      if (pat[k]) nxt = nxt + 8'h01;
      tick();
    end
    check("sg_count", delivered.size(), 2);
    check("sg_first", (delivered.size() > 0) ? delivered[0] : 8'hxx, 8'h40);
    check("sg_second", (delivered.size() > 1) ? delivered[1] : 8'hxx, 8'h41);
    check("sg_held", {n_out_valid, n_occ, n_out_data}, {1'b1, 2'd1, 8'h42});
    n_in_valid = 0; n_out_ready = 1;
    tick();
    check("sg_empty", n_out_valid, 0);

    // Asynchronous reset mid-cycle while busy
    s_in_valid = 1; s_out_ready = 0; s_in_data = 8'h77;
    n_in_valid = 1; n_out_ready = 0; n_in_data = 8'h66;
    tick();
    s_in_valid = 0; n_in_valid = 0;
    check("ar_busy", {s_out_valid, s_out_data}, {1'b1, 8'h77});
    #2 reset = 1'b1;
    #1;
    check("ar_s", {s_out_valid, s_occ, s_in_ready, s_out_data}, {1'b0, 2'd0, 1'b1, RSTD});
    check("ar_n", {n_out_valid, n_occ, n_in_ready, n_out_data}, {1'b0, 2'd0, 1'b1, RSTD});
    @(negedge clock) reset = 1'b0;
    tick();
    check("ar_rel", {s_in_ready, s_out_valid}, {1'b1, 1'b0});

    // Random traffic against reference queues
    for (int c = 0; c < 10000; c++) begin
      s_in_valid  = ($urandom_range(0, 9) < 7);
      s_in_data   = s_in_valid ? DW'($urandom) : 'x;
      s_out_ready = ($urandom_range(0, 9) < 6);
      s_flush     = ($urandom_range(0, 99) < 3);
      n_in_valid  = ($urandom_range(0, 9) < 7);
      n_in_data   = n_in_valid ? DW'($urandom) : 'x;
      n_out_ready = ($urandom_range(0, 9) < 6);
      n_flush     = ($urandom_range(0, 99) < 3);
      #1;

      ev   = (sq.size() != 0);
      eocc = 2'(sq.size());
      erdy = (sq.size() < 2);
      if (ev) begin
        edata = sq[0];
        check("rnd_s", {s_out_valid, s_occ, s_in_ready, s_out_data}, {ev, eocc, erdy, edata});
      end else begin
        check("rnd_s_idle", {s_out_valid, s_occ, s_in_ready}, {ev, eocc, erdy});
      end
      s_in  = s_in_valid && erdy;
      s_out = ev && s_out_ready;

      ev   = (nq.size() != 0);
      eocc = 2'(nq.size());
      erdy = !ev || n_out_ready;
      if (ev) begin
        edata = nq[0];
        check("rnd_n", {n_out_valid, n_occ, n_in_ready, n_out_data}, {ev, eocc, erdy, edata});
      end else begin
        check("rnd_n_idle", {n_out_valid, n_occ, n_in_ready}, {ev, eocc, erdy});
      end
      n_in  = n_in_valid && erdy;
      n_out = ev && n_out_ready;

      if (s_flush) sq.delete();
      else begin
        if (s_out) void'(sq.pop_front());
        if (s_in) sq.push_back(s_in_data);
      end
      if (n_flush) nq.delete();
      else begin
        if (n_out) void'(nq.pop_front());
        if (n_in) nq.push_back(n_in_data);
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
